ubtb_update_queue: RTL and testbench
====================================

UBTB_UPDATE_QUEUE -- requirements
Module: ubtb_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter ADDR_W, default 39, giving the width of the prediction-block start address.
REQ-003 The block SHALL have parameter INFO_W, default 96, giving the width of the opaque update payload (btbEntry, ctr meta, realTaken, allocSlot).
REQ-004 Port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port `flush`, input, 1: discard all queued updates.
REQ-007 Port `in_valid`, input, 1: a commit-side update request is present.
REQ-008 Port `in_ready`, output, 1: the queue accepts the request this cycle.
REQ-009 Port `in_start_addr`, input, ADDR_W: start address of the updated block.
REQ-010 Port `in_info`, input, INFO_W: update payload.
REQ-011 Port `out_valid`, output, 1: an update is presented to the uBTB update port.
REQ-012 Port `out_ready`, input, 1: the uBTB consumes the update this cycle.
REQ-013 Port `out_start_addr`, output, ADDR_W: head entry address.
REQ-014 Port `out_info`, output, INFO_W: head entry payload.
REQ-015 Port `count`, output, $clog2(DEPTH)+1: number of valid entries.
REQ-016 Port `merge_cnt`, output, 16: saturating count of merged requests.

Function
REQ-017 Storage SHALL be a circular buffer with a head pointer, a tail pointer and `count`; pointers wrap from DEPTH-1 to 0.
REQ-018 out_valid SHALL equal (count != 0); out_start_addr and out_info SHALL reflect the head entry combinationally.
REQ-019 When out_valid is 0, out_start_addr and out_info SHALL be 0.
REQ-020 Dequeue SHALL occur on out_valid & out_ready: head advances by 1 and count decrements.
REQ-021 Merge hit SHALL be asserted when in_valid is high and in_start_addr equals the address of a valid entry.
- The head entry is excluded from the match in a cycle where it is dequeued.
- Addresses in the queue are unique, so at most one entry can match.
REQ-022 On a merge hit with in_ready high, the matching entry's in_info SHALL be overwritten (newest wins).
- Its queue position, tail and count are unchanged.
- merge_cnt increments, saturating at 16'hFFFF.
REQ-023 On no merge hit, enqueue SHALL occur on in_valid & in_ready: the entry is written at tail, tail advances by 1 and count increments.
REQ-024 in_ready SHALL equal ~flush & ((count < DEPTH) | merge_hit); a same-cycle dequeue does not free space for a non-merging enqueue when full (no full bypass).
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-026 There SHALL be no empty bypass: an accepted request appears on out_valid at the earliest in the following cycle (latency 1).
REQ-027 flush SHALL have priority over enqueue, merge and dequeue.
- Next cycle: count=0, head=tail=0, out_valid=0.
- merge_cnt is unaffected.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 While rst=1 at a clock edge, head, tail and count SHALL be cleared to 0, merge_cnt cleared to 0, and all entry valid state cleared.
- Outputs after reset: out_valid=0, out_start_addr=0, out_info=0, count=0, in_ready=1 (flush=0).
REQ-030 rst asserted mid-operation SHALL discard all queued entries with the same result as REQ-029, taking priority over flush, enqueue and dequeue.

Verification
REQ-031 Push A=0x1000 and B=0x1020 with out_ready=0 -> count=2, out_start_addr=0x1000; after two out_ready cycles the uBTB receives 0x1000 then 0x1020 in that order, then count=0 and out_valid=0.
REQ-032 Fill to DEPTH=4 with distinct addresses, then hold in_valid with new address 0x2000 while out_ready=1 -> in_ready=0 that cycle and head dequeued; next cycle count=3, in_ready=1, and 0x2000 is accepted.
REQ-033 Queue holds 0x1000 (info 5) and 0x1040; push 0x1040 with info 9 -> count stays 2, merge_cnt=1; the second dequeue shows out_info=9.
REQ-034 Head=0x1000 being dequeued while in 0x1000 arrives -> no merge: the new request enqueues at tail, count unchanged, and 0x1000 reappears later with the new info.
REQ-035 Three entries queued; assert flush with in_valid=1 -> in_ready=0, next cycle count=0, out_valid=0, merge_cnt unchanged; then apply rst -> merge_cnt=0.
REQ-036 Run 20 push/pop cycles at DEPTH=4 with random out_ready -> pointer wrap-around preserves FIFO order and count matches a reference model every cycle.

Source files
------------

// File: rtl/ubtb_update_queue.sv
// rtl/ubtb_update_queue.sv - uBTB update queue: circular buffer with address merge, flush and saturating merge counter
module ubtb_update_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 39,
  parameter int INFO_W = 96
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_start_addr,
  input  logic [INFO_W-1:0]       in_info,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_start_addr,
  output logic [INFO_W-1:0]       out_info,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             merge_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       merge_cnt_q, merge_cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [INFO_W-1:0] info_q [DEPTH];
  logic [INFO_W-1:0] info_d [DEPTH];

  logic              deq;
  logic              enq;
  logic              merge_hit;
  logic              merge_do;
  logic [DEPTH-1:0]  match_vec;
  logic [PTR_W-1:0]  match_idx;

  // Head entry is presented combinationally; zeroed while the queue is empty
  always_comb begin
    out_valid      = (count_q != '0);
    out_start_addr = '0;
    out_info       = '0;
    if (out_valid) begin
      out_start_addr = addr_q[head_q];
      out_info       = info_q[head_q];
    end
  end

  assign deq       = out_valid & out_ready & ~flush;
  assign count     = count_q;
  assign merge_cnt = merge_cnt_q;

  // Address match against live entries; the head leaving this cycle cannot absorb a merge
  always_comb begin
    match_vec = '0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == in_start_addr) &&
          !(out_valid && out_ready && (head_q == PTR_W'(i)))) begin
        match_vec[i] = 1'b1;
        match_idx    = PTR_W'(i);
      end
    end
  end

  assign merge_hit = in_valid & (|match_vec);
  // A dequeue in the same cycle never frees room for a new entry when full
  assign in_ready  = ~flush & ((count_q < CNT_W'(DEPTH)) | merge_hit);
  assign merge_do  = merge_hit & in_ready;
  assign enq       = in_valid & in_ready & ~merge_hit;

  // Next-state: flush empties the queue; otherwise apply dequeue, merge and enqueue
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    merge_cnt_d = merge_cnt_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    info_d      = info_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (deq) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (merge_do) begin
        info_d[match_idx] = in_info;
        if (merge_cnt_q != 16'hFFFF) begin
          merge_cnt_d = merge_cnt_q + 16'd1;
        end
      end
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = in_start_addr;
        info_d[tail_q]  = in_info;
        tail_d          = tail_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      merge_cnt_q <= '0;
      valid_q     <= '0;
      addr_q      <= '{default: '0};
      info_q      <= '{default: '0};
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      merge_cnt_q <= merge_cnt_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      info_q      <= info_d;
    end
  end

endmodule

// File: tb/tb_ubtb_update_queue.sv
// tb/tb_ubtb_update_queue.sv - self-checking bench for ubtb_update_queue against a queue-based reference model
module tb_ubtb_update_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 39;
  localparam int INFO_W = 96;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_start_addr;
  logic [INFO_W-1:0]      in_info;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_W-1:0]      out_start_addr;
  logic [INFO_W-1:0]      out_info;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            merge_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [INFO_W-1:0] i;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_mc;

  always #5 clk = ~clk;

  ubtb_update_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INFO_W(INFO_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_start_addr  (in_start_addr),
    .in_info        (in_info),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_start_addr (out_start_addr),
    .out_info       (out_info),
    .count          (count),
    .merge_cnt      (merge_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs and in_ready vs model, advance model at posedge
  task automatic cycle(input logic iv, input logic [ADDR_W-1:0] a, input logic [INFO_W-1:0] inf,
                       input logic ordy, input logic fl);
    int                hit_idx;
    logic              deq;
    logic              rdy;
    logic [ADDR_W-1:0] ea;
    logic [INFO_W-1:0] ei;
    ent_t              e;
    in_valid      = iv;
    in_start_addr = a;
    in_info       = inf;
    out_ready     = ordy;
    flush         = fl;
    #1;
    ea = '0;
    ei = '0;
    if (mq.size() != 0) begin
      ea = mq[0].a;
      ei = mq[0].i;
    end
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_start_addr", out_start_addr, ea);
    chk("out_info", out_info, ei);
    chk("count", count, mq.size());
    chk("merge_cnt", merge_cnt, m_mc);
    deq = (mq.size() != 0) && ordy && !fl;
    hit_idx = -1;
    if (iv) begin
      foreach (mq[k]) begin
        if (mq[k].a == a && !((mq.size() != 0) && ordy && k == 0)) hit_idx = k;
      end
    end
    rdy = !fl && ((mq.size() < DEPTH) || hit_idx >= 0);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (iv && rdy && hit_idx >= 0) begin
        mq[hit_idx].i = inf;
        if (m_mc < 65535) m_mc++;
      end
      if (deq) void'(mq.pop_front());
      if (iv && rdy && hit_idx < 0) begin
        e.a = a;
        e.i = inf;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_mc = 0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [INFO_W-1:0] inf);
    cycle(1'b1, a, inf, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH; n++) idle(1'b1);
  endtask

  initial begin
    logic [ADDR_W-1:0] a_r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_start_addr = '0; in_info = '0;
    m_mc = 0;
    @(negedge clk);
    do_reset();

    // reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_merge_cnt", merge_cnt, 0);
    idle(1'b0);

    // FIFO order of two pushes
    push(39'h1000, 96'h1);
    push(39'h1020, 96'h2);
    idle(1'b0);
    chk("fifo_cnt2", count, 2);
    chk("fifo_head", out_start_addr, 39'h1000);
    idle(1'b1);
    chk("fifo_second", out_start_addr, 39'h1020);
    idle(1'b1);
    chk("fifo_empty_cnt", count, 0);
    chk("fifo_empty_valid", out_valid, 0);

    // full, no bypass on dequeue
    push(39'h1100, 96'h11);
    push(39'h1120, 96'h12);
    push(39'h1140, 96'h13);
    push(39'h1160, 96'h14);
    in_valid = 1'b1; in_start_addr = 39'h2000; out_ready = 1'b1; #1;
    chk("full_in_ready", in_ready, 0);
    cycle(1'b1, 39'h2000, 96'h20, 1'b1, 1'b0);
    chk("full_cnt3", count, 3);
    chk("full_ready_again", in_ready, 1);
    cycle(1'b1, 39'h2000, 96'h20, 1'b0, 1'b0);
    chk("full_cnt4", count, 4);
    drain();

    // merge overwrite
    push(39'h1000, 96'h5);
    push(39'h1040, 96'h6);
    push(39'h1040, 96'h9);
    chk("merge_cnt1", merge_cnt, 1);
    chk("merge_count2", count, 2);
    idle(1'b1);
    chk("merge_info9", out_info, 96'h9);
    drain();

    // head being dequeued does not merge
    push(39'h1000, 96'h5);
    push(39'h1040, 96'h6);
    cycle(1'b1, 39'h1000, 96'h7, 1'b1, 1'b0);
    chk("nomerge_cnt", count, 2);
    chk("nomerge_mc", merge_cnt, 1);
    idle(1'b1);
    chk("nomerge_reappear", out_start_addr, 39'h1000);
    chk("nomerge_info", out_info, 96'h7);
    drain();

    // flush then reset
    push(39'h3000, 96'h1);
    push(39'h3020, 96'h2);
    push(39'h3040, 96'h3);
    in_valid = 1'b1; in_start_addr = 39'h3060; flush = 1'b1; #1;
    chk("flush_in_ready", in_ready, 0);
    cycle(1'b1, 39'h3060, 96'h4, 1'b0, 1'b1);
    chk("flush_cnt", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_mc", merge_cnt, 1);
    do_reset();
    #1;
    chk("reset_mc", merge_cnt, 0);

    // random traffic; the first 20 cycles never flush
    for (int n = 0; n < 300; n++) begin
      a_r = 39'h1000 + 39'(32 * $urandom_range(0, 5));
      cycle($urandom_range(0, 3) != 0, a_r, {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), (n >= 20) && ($urandom_range(0, 24) == 0));
      if (n == 180) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
